// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
//   Source side of a 4-phase request/acknowledge handshake that carries one
//   DATA_W-bit word into another clock domain. The word is held stable on
//   xfer_data while xfer_req is raised. The destination acknowledge is
//   brought into clk through a 2-flop synchronizer. An optional timeout
//   abandons the request if the acknowledge never arrives.
//
// Parameters
//   DATA_W   width of the transferred word
//   TIMEOUT  clk cycles to wait for acknowledge (16-bit); 0 disables it
//
// Ports
//   clk             source-domain clock
//   rst_n           asynchronous active-low reset
//   src_valid       source offers src_data
//   src_data        word offered by the source
//   src_ready       block accepts a word this cycle
//   xfer_data       word presented to the destination domain
//   xfer_req        4-phase request to the destination domain
//   xfer_ack_async  destination acknowledge, not yet synchronized
//   done            one-cycle pulse when a handshake completes
//   timeout_err     one-cycle pulse when the acknowledge wait expires
//   busy            a transfer is in progress
//
// State    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for src_valid; held off while a stale ack is high
// ASSERT   | xfer_req high, waiting for ack_s (or the timeout)
// RELEASE  | xfer_req low, waiting for ack_s to fall, then pulse done
module cdc_handshake_tx #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic [DATA_W-1:0] xfer_data,
    output logic              xfer_req,
    input  logic              xfer_ack_async,
    output logic              done,
    output logic              timeout_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam bit          TO_EN    = (TIMEOUT != 0);
    // Counter starts at 0 on ASSERT entry, so the limit is reached after
    // TIMEOUT cycles of waiting.
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT - 1);

    state_t              state, state_nxt;
    logic                ack_m, ack_s;
    logic [15:0]         cnt, cnt_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                req_nxt;
    logic                done_nxt;
    logic                to_nxt;

    // Two-flop synchronizer; only ack_s is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= xfer_ack_async;
            ack_s <= ack_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 16'd0;
            xfer_data   <= '0;
            xfer_req    <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            xfer_data   <= data_nxt;
            xfer_req    <= req_nxt;
            done        <= done_nxt;
            timeout_err <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = xfer_data;
        req_nxt   = xfer_req;
        done_nxt  = 1'b0;
        to_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // A stale acknowledge blocks acceptance so a new request
                // never overlaps the previous ack phase.
                if (src_valid && !ack_s) begin
                    data_nxt  = src_data;
                    req_nxt   = 1'b1;
                    cnt_nxt   = 16'd0;
                    state_nxt = ASSERT;
                end
            end
            ASSERT: begin
                // Acknowledge is checked first so it wins a same-cycle race
                // against the timeout limit.
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = RELEASE;
                end else if (TO_EN && (cnt == TO_LIMIT)) begin
                    req_nxt   = 1'b0;
                    to_nxt    = 1'b1;
                    state_nxt = RELEASE;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            RELEASE: begin
                req_nxt = 1'b0;
                if (!ack_s) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign src_ready = (state == IDLE) && !ack_s;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cdc_handshake_tx.sv
module tb_cdc_handshake_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic [7:0] xfer_data;
    logic       xfer_req;
    logic       xfer_ack_async;
    logic       done;
    logic       timeout_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Destination model: ack 3 cycles after req rises, drop 3 after req falls.
    logic dest_en   = 1'b1;
    logic model_ack = 1'b0;
    logic man_ack   = 1'b0;
    int   dcnt      = 0;

    assign xfer_ack_async = dest_en ? model_ack : man_ack;

    cdc_handshake_tx #(.DATA_W(8), .TIMEOUT(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .src_ready      (src_ready),
        .xfer_data      (xfer_data),
        .xfer_req       (xfer_req),
        .xfer_ack_async (xfer_ack_async),
        .done           (done),
        .timeout_err    (timeout_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!dest_en) begin
            dcnt = 0;
            model_ack = 1'b0;
        end else if (xfer_req && !model_ack) begin
            dcnt++;
            if (dcnt >= 3) begin
                model_ack = 1'b1;
                dcnt = 0;
            end
        end else if (!xfer_req && model_ack) begin
            dcnt++;
            if (dcnt >= 3) begin
                model_ack = 1'b0;
                dcnt = 0;
            end
        end else begin
            dcnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (xfer_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", xfer_req); end
        checks++; if (xfer_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", xfer_data); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_to got %b exp 0", timeout_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", src_ready); end
    endtask

    task automatic test_basic();
        int dones = 0;
        int tos = 0;
        int bad = 0;
        dest_en = 1'b1;
        tick();
        checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL basic_ready0 got %b exp 1", src_ready); end
        src_data = 8'hA5; src_valid = 1'b1;
        tick();
        src_valid = 1'b0; src_data = 8'h00;
        checks++; if (xfer_req !== 1'b1) begin errors++; $display("FAIL basic_req got %b exp 1", xfer_req); end
        checks++; if (xfer_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", xfer_data); end
        checks++; if (busy !== 1'b1 || src_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got busy=%b ready=%b exp 1/0", busy, src_ready); end
        for (int k = 0; k < 40; k++) begin
            tick();
            if (xfer_data !== 8'hA5) bad++;
            if (done) dones++;
            if (timeout_err) tos++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_hold got %0d bad cycles exp 0", bad); end
        checks++; if (dones != 1) begin errors++; $display("FAIL basic_done got %0d pulses exp 1", dones); end
        checks++; if (tos != 0) begin errors++; $display("FAIL basic_to got %0d pulses exp 0", tos); end
        checks++; if (src_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_end got ready=%b busy=%b exp 1/0", src_ready, busy); end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int bad = 0;
        bit after_first = 0;
        dest_en = 1'b1;
        src_data = 8'h11; src_valid = 1'b1;
        tick();
        src_data = 8'h22;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (after_first) begin
                checks++; if (xfer_data !== 8'h22 || xfer_req !== 1'b1) begin errors++; $display("FAIL b2b_second got data=%h req=%b exp 22/1", xfer_data, xfer_req); end
                src_valid = 1'b0;
                after_first = 0;
            end
            if (dones == 0 && xfer_data !== 8'h11) bad++;
            if (done) begin
                dones++;
                if (dones == 1) after_first = 1;
            end
        end
        src_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_first_hold got %0d bad cycles exp 0", bad); end
        checks++; if (dones != 2) begin errors++; $display("FAIL b2b_done got %0d pulses exp 2", dones); end
        checks++; if (xfer_data !== 8'h22 || src_ready !== 1'b1) begin errors++; $display("FAIL b2b_end got data=%h ready=%b exp 22/1", xfer_data, src_ready); end
    endtask

    task automatic test_timeout();
        int tos = 0;
        int dones = 0;
        int both = 0;
        int to_k = -1;
        int done_k = -1;
        logic req_at_to = 1'bx;
        dest_en = 1'b0; man_ack = 1'b0;
        src_data = 8'h3C; src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        checks++; if (xfer_req !== 1'b1) begin errors++; $display("FAIL to_req got %b exp 1", xfer_req); end
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (timeout_err) begin tos++; to_k = k; req_at_to = xfer_req; end
            if (done) begin dones++; done_k = k; end
            if (done && timeout_err) both++;
        end
        checks++; if (to_k != 16) begin errors++; $display("FAIL to_cycle got %0d exp 16", to_k); end
        checks++; if (tos != 1) begin errors++; $display("FAIL to_count got %0d exp 1", tos); end
        checks++; if (req_at_to !== 1'b0) begin errors++; $display("FAIL to_req_clear got %b exp 0", req_at_to); end
        checks++; if (done_k != 17 || dones != 1) begin errors++; $display("FAIL to_done got cycle %0d count %0d exp 17/1", done_k, dones); end
        checks++; if (both != 0) begin errors++; $display("FAIL to_excl got %0d overlaps exp 0", both); end
        checks++; if (xfer_data !== 8'h3C) begin errors++; $display("FAIL to_data got %h exp 3c", xfer_data); end
    endtask

    task automatic test_race();
        int tos = 0;
        int dones = 0;
        int done_k = -1;
        int fall_k = -1;
        dest_en = 1'b0; man_ack = 1'b0;
        src_data = 8'h4B; src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 13) man_ack = 1'b1;
            if (k == 20) man_ack = 1'b0;
            if (timeout_err) tos++;
            if (done) begin dones++; done_k = k; end
            if (!xfer_req && fall_k < 0) fall_k = k;
        end
        checks++; if (tos != 0) begin errors++; $display("FAIL race_to got %0d pulses exp 0", tos); end
        checks++; if (fall_k != 16) begin errors++; $display("FAIL race_req_fall got %0d exp 16", fall_k); end
        checks++; if (dones != 1 || done_k != 23) begin errors++; $display("FAIL race_done got cycle %0d count %0d exp 23/1", done_k, dones); end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int reqs = 0;
        dest_en = 1'b1;
        src_data = 8'h5A; src_valid = 1'b1;
        tick();
        src_valid = 1'b0;
        checks++; if (xfer_req !== 1'b1) begin errors++; $display("FAIL rmid_req got %b exp 1", xfer_req); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (xfer_req !== 1'b0 || xfer_data !== 8'h00) begin errors++; $display("FAIL rmid_async got req=%b data=%h exp 0/00", xfer_req, xfer_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) dones++;
            if (xfer_req) reqs++;
        end
        checks++; if (dones != 0 || reqs != 0) begin errors++; $display("FAIL rmid_after got done=%0d req=%0d exp 0/0", dones, reqs); end
        checks++; if (src_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got ready=%b busy=%b exp 1/0", src_ready, busy); end
    endtask

    task automatic test_stale_ack();
        int bad = 0;
        int dones = 0;
        dest_en = 1'b0; man_ack = 1'b1; src_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL stale_ready got %b exp 0", src_ready); end
        src_data = 8'h77; src_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (src_ready || xfer_req || busy) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stale_block got %0d bad cycles exp 0", bad); end
        man_ack = 1'b0;
        tick();
        checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL stale_fall1 got %b exp 0", src_ready); end
        tick();
        checks++; if (src_ready !== 1'b1 || xfer_req !== 1'b0) begin errors++; $display("FAIL stale_fall2 got ready=%b req=%b exp 1/0", src_ready, xfer_req); end
        tick();
        src_valid = 1'b0;
        checks++; if (xfer_req !== 1'b1 || xfer_data !== 8'h77) begin errors++; $display("FAIL stale_accept got req=%b data=%h exp 1/77", xfer_req, xfer_data); end
        dest_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) dones++;
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL stale_done got %0d exp 1", dones); end
    endtask

    initial begin
        rst_n = 1'b0;
        src_valid = 1'b0;
        src_data = 8'h00;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_back_to_back();
        test_timeout();
        test_race();
        test_reset_mid();
        test_stale_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
